// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin arbiter sharing one register bus between two masters
//
// Purpose: serialises register transactions from two masters onto a single
// register bus. Only one access is on the bus at a time. On contention the
// master that was not granted last wins. Read data is returned RD_LAT cycles
// after the read strobe.
//
// Ports:
//   clks, reset              clock, synchronous active-high reset
//   m0_*/m1_* req/we/addr/wdata   per-master request, held until ack
//   m0_ack/m1_ack            one-cycle completion pulse
//   m0_rdata/m1_rdata        per-master read data, held until that master's next read ack
//   cpu_wr/cpu_rd            one-cycle register write/read strobes
//   cpu_wr_addr/cpu_data_in  latched bus address and write data, held while idle
//   cpu_data_out             registered read data from the register block
//   arb_busy/arb_owner       FSM not idle / current or last granted master
`timescale 1ns/1ps
module reg_bus_arbiter #(
    parameter int CPU_ADDR_WIDTH = 12,
    parameter int CPU_DATA_WIDTH = 32,
    parameter int RD_LAT         = 2
) (
    input  logic                      clks,
    input  logic                      reset,
    input  logic                      m0_req,
    input  logic                      m0_we,
    input  logic [CPU_ADDR_WIDTH-1:0] m0_addr,
    input  logic [CPU_DATA_WIDTH-1:0] m0_wdata,
    input  logic                      m1_req,
    input  logic                      m1_we,
    input  logic [CPU_ADDR_WIDTH-1:0] m1_addr,
    input  logic [CPU_DATA_WIDTH-1:0] m1_wdata,
    output logic                      m0_ack,
    output logic                      m1_ack,
    output logic [CPU_DATA_WIDTH-1:0] m0_rdata,
    output logic [CPU_DATA_WIDTH-1:0] m1_rdata,
    output logic                      cpu_wr,
    output logic                      cpu_rd,
    output logic [CPU_ADDR_WIDTH-1:0] cpu_wr_addr,
    output logic [CPU_DATA_WIDTH-1:0] cpu_data_in,
    input  logic [CPU_DATA_WIDTH-1:0] cpu_data_out,
    output logic                      arb_busy,
    output logic                      arb_owner
);

    typedef enum logic [1:0] {IDLE, WR, RD_WAIT, DONE} state_t;

    // Counter value in the last RD_WAIT cycle; data is captured at the edge ending it.
    localparam logic [2:0] RD_LAST = 3'(RD_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       prio;       // master that wins the next simultaneous request
    logic [2:0] cnt;
    logic       any_req;
    logic       grant;
    logic       grant_we;
    logic       rd_last;

    always_comb begin
        any_req  = m0_req | m1_req;
        grant    = 1'b0;
        if (m0_req && m1_req) begin
            grant = prio;
        end else if (m1_req) begin
            grant = 1'b1;
        end
        grant_we = grant ? m1_we : m0_we;
        rd_last  = (state == RD_WAIT) && (cnt == RD_LAST);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = grant_we ? WR : RD_WAIT;
            WR:      state_nxt = DONE;
            RD_WAIT: if (rd_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cpu_wr   = (state == WR);
        cpu_rd   = (state == RD_WAIT) && (cnt == 3'd0);
        m0_ack   = (state == DONE) && !arb_owner;
        m1_ack   = (state == DONE) && arb_owner;
        arb_busy = (state != IDLE);
    end

    always_ff @(posedge clks) begin
        if (reset) begin
            state       <= IDLE;
            prio        <= 1'b0;
            arb_owner   <= 1'b0;
            cnt         <= 3'd0;
            cpu_wr_addr <= '0;
            cpu_data_in <= '0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                arb_owner   <= grant;
                prio        <= ~grant;
                cnt         <= 3'd0;
                cpu_wr_addr <= grant ? m1_addr  : m0_addr;
                cpu_data_in <= grant ? m1_wdata : m0_wdata;
            end
            if (state == RD_WAIT) begin
                cnt <= cnt + 3'd1;
            end
            if (rd_last) begin
                if (arb_owner) begin
                    m1_rdata <= cpu_data_out;
                end else begin
                    m0_rdata <= cpu_data_out;
                end
            end
        end
    end

endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Two-requester arbiter that shares the single user-logic register bus (cpu_wr / cpu_rd / cpu_wr_addr / cpu_data_in / cpu_data_out) between two independent masters, e.g. the host BAR access path and an internal self-test/config sequencer. It serialises their transactions with fair round-robin arbitration, drives one register-bus access at a time and returns read data after a fixed, parameterised read latency. It sits directly in front of the register access block.

## Interface
Parameters:
- CPU_ADDR_WIDTH, 12, register address width
- CPU_DATA_WIDTH, 32, register data width
- RD_LAT, 2, cycles from cpu_rd assertion to the edge at which cpu_data_out is sampled; legal range 1..7

Ports:
- clks  input  1  clock; single clock domain
- reset  input  1  synchronous, active-high reset
- m0_req / m1_req  input  1  transaction request; held high until the matching ack
- m0_we / m1_we  input  1  1 = write, 0 = read; held with req
- m0_addr / m1_addr  input  CPU_ADDR_WIDTH  register address; held with req
- m0_wdata / m1_wdata  input  CPU_DATA_WIDTH  write data; held with req
- m0_ack / m1_ack  output  1  one-cycle completion pulse
- m0_rdata / m1_rdata  output  CPU_DATA_WIDTH  read data, valid in the ack cycle, held until that master's next read ack
- cpu_wr  output  1  register write strobe, one cycle per write
- cpu_rd  output  1  register read strobe, one cycle per read
- cpu_wr_addr  output  CPU_ADDR_WIDTH  shared register address (used for both reads and writes)
- cpu_data_in  output  CPU_DATA_WIDTH  write data to register block
- cpu_data_out  input  CPU_DATA_WIDTH  registered read data from register block
- arb_busy  output  1  high whenever FSM is not IDLE
- arb_owner  output  1  index of the current or last granted master

## Operation
- FSM states: IDLE, WR, RD_WAIT, DONE.
- IDLE: if any req is high, select a winner, latch its we/addr/wdata into the bus registers, set arb_owner; go to WR (we=1) or RD_WAIT (we=0). No req: stay.
- Round-robin: a single requester is granted immediately; on simultaneous requests the master not granted last wins. After reset, m0 has priority for the first contention.
- WR: cpu_wr=1 for exactly this cycle, cpu_wr_addr/cpu_data_in driven from latched values; -> DONE.
- RD_WAIT: cpu_rd=1 in the first RD_WAIT cycle only; 3-bit counter counts RD_LAT cycles; at the edge ending the RD_LAT-th cycle cpu_data_out is captured into the owner's rdata register; -> DONE.
- DONE: owner's ack=1 for one cycle; -> IDLE. The non-owner's ack and rdata never change.
- cpu_wr_addr and cpu_data_in hold their last value while idle (register-block read mux decodes the address continuously).
- A write never changes either rdata.
- Requester dropping req before ack is a protocol violation; the transaction still completes and ack still pulses.
- req still high in the cycle after ack = new transaction.

## Timing
- Reset values: cpu_wr=0, cpu_rd=0, cpu_wr_addr=0, cpu_data_in=0, m0/m1_ack=0, m0/m1_rdata=0, arb_busy=0, arb_owner=0, FSM=IDLE, RR pointer favours m0.
- Let T0 = IDLE cycle in which req is sampled. Write: cpu_wr in T1, ack in T2, IDLE in T3 (3-cycle occupancy).
- Read: cpu_rd in T1, data sampled at end of T(RD_LAT), ack+rdata valid in T(RD_LAT+1), IDLE in T(RD_LAT+2).
- Both masters requesting continuously: grants strictly alternate; no master waits more than one foreign transaction.
- Reset asserted mid-transaction: next cycle FSM=IDLE, all strobes and acks 0, no ack issued for the aborted transaction, rdata cleared.
- New req arriving during a transaction is held off until IDLE; never aborts the current one.

## Test plan
- Single write: m0 write addr 0x002 data 0x0000_0011 at T0 -> cpu_wr=1 only in T1 with cpu_wr_addr=0x002, cpu_data_in=0x11; m0_ack in T2; m1_ack stays 0.
- Single read, RD_LAT=2: m1 read addr 0x000, register model returns 0x2018_0308 one cycle after address -> cpu_rd only in T1, m1_ack and m1_rdata=0x2018_0308 in T3; m0_rdata unchanged.
- Contention after reset: m0 and m1 both request at T0 -> m0 served first, m1 granted in the IDLE cycle after m0_ack; with both held continuously for 6 transactions, owner sequence 0,1,0,1,0,1.
- End-to-end adder: m0 writes 0x002=5, m1 writes 0x003=7, m0 reads 0x004 -> m0_rdata=12.
- Reset mid-read: assert reset in RD_WAIT -> next cycle arb_busy=0, cpu_rd=0, no ack ever pulses for that read, rdata=0; a subsequent read completes normally.
- RD_LAT sweep 1 and 7: read latency ack at T2 and T8 respectively, data correct.
